// File: rtl/stream_mux_4to1_rr_if.sv
// Handshake bundle for the 4-to-1 round-robin stream mux: four valid/ready input
// channels on one side, one registered valid/ready output plus channel tag on the other.
interface stream_mux_4to1_rr_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_ready;

    // Environment side: drives the input channels and the downstream ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

    // Mux side: consumes the input channels and presents the output register.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );
endinterface

// File: rtl/stream_mux_4to1_rr.sv
// Registered 4-to-1 stream mux with round-robin arbitration; out_sel tags the source channel.
// Optional per-channel saturating grant counters are built when STREAM_MUX_STATS_EN is defined.
module stream_mux_4to1_rr #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_mux_4to1_rr_if.slave bus
`ifdef STREAM_MUX_STATS_EN
    ,
    output logic [4*CNT_W-1:0] grant_cnt
`endif
);

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("stream_mux_4to1_rr: DATA_W and CNT_W must be at least 1");
    end

    logic [DATA_W-1:0] ch_data [4];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [1:0]        out_sel_q,   out_sel_d;
    logic [1:0]        rr_ptr_q,    rr_ptr_d;

    logic              any_valid;
    logic              load_en;
    logic              xfer;
    logic [1:0]        gnt;
    logic [1:0]        scan_idx;
    logic              found;

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign ch_data[gi] = bus.in_data[gi*DATA_W +: DATA_W];
    end

    // Nothing is accepted while reset is held, so in_ready stays low throughout.
    assign any_valid = |bus.in_valid;
    assign load_en   = !out_valid_q || bus.out_ready;
    assign xfer      = rst_n && load_en && any_valid;

    // First requesting channel at or after the pointer, wrapping modulo 4.
    always_comb begin
        gnt      = rr_ptr_q;
        scan_idx = rr_ptr_q;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!found && bus.in_valid[scan_idx]) begin
                gnt   = scan_idx;
                found = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
        assign bus.in_ready[gi] = xfer && (gnt == 2'(gi));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt];
            out_sel_d   = gnt;
            rr_ptr_d    = gnt + 2'd1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            rr_ptr_q    <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

`ifdef STREAM_MUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counters stick at all-ones instead of wrapping.
    for (genvar gi = 0; gi < 4; gi++) begin : g_stats
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (bus.in_ready[gi] && bus.in_valid[gi] && (cnt_q[gi] != '1)) begin
                cnt_d[gi] = cnt_q[gi] + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[gi] <= '0;
            end else begin
                cnt_q[gi] <= cnt_d[gi];
            end
        end

        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_stream_mux_4to1_rr.sv
// Directed table-driven bench for stream_mux_4to1_rr, plus hand-written reset and
// counter-saturation sequences (the latter only when STREAM_MUX_STATS_EN is defined).
module tb_stream_mux_4to1_rr;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 22;

    typedef struct {
        logic [3:0]  in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic [3:0]  exp_in_ready;
        logic        exp_out_valid;
        logic [7:0]  exp_out_data;
        logic [1:0]  exp_out_sel;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    stream_mux_4to1_rr_if #(.DATA_W(DATA_W)) bus ();

`ifdef STREAM_MUX_STATS_EN
    logic [4*CNT_W-1:0] grant_cnt;

    stream_mux_4to1_rr #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .grant_cnt (grant_cnt)
    );
`else
    stream_mux_4to1_rr #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check combinational ready, clock, check registers.
    task automatic step(input string tag, input vec_t v);
        bus.in_valid  = v.in_valid;
        bus.in_data   = v.in_data;
        bus.out_ready = v.out_ready;
        #1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(v.exp_in_ready));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.exp_out_valid));
        check({tag, " out_data"},  32'(bus.out_data),  32'(v.exp_out_data));
        check({tag, " out_sel"},   32'(bus.out_sel),   32'(v.exp_out_sel));
        $display("%s: in_valid=%b out_ready=%b in_ready=%b -> out_valid=%b out_data=%h out_sel=%0d",
                 tag, v.in_valid, v.out_ready, v.exp_in_ready,
                 bus.out_valid, bus.out_data, bus.out_sel);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        // in_data packs ch3..ch0 from MSB to LSB
        //            in_valid in_data       ordy rdy      ov    od     os
        vecs[0]  = '{4'hF,    32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[1]  = '{4'hF,    32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[2]  = '{4'hF,    32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
        vecs[3]  = '{4'hF,    32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
        vecs[4]  = '{4'hF,    32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[5]  = '{4'hF,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
        vecs[6]  = '{4'hF,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
        vecs[7]  = '{4'hF,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
        vecs[8]  = '{4'hF,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
        vecs[9]  = '{4'hF,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
        vecs[10] = '{4'hF,    32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[11] = '{4'h0,    32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
        vecs[12] = '{4'b0100, 32'h13A51110, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[13] = '{4'b1000, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
        vecs[14] = '{4'b0011, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[15] = '{4'b0011, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[16] = '{4'b0011, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[17] = '{4'h0,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};
        vecs[18] = '{4'h0,    32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
        vecs[19] = '{4'h0,    32'h13121110, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0};
        vecs[20] = '{4'b0010, 32'h13121110, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[21] = '{4'hF,    32'h13121110, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};

        // Asynchronous reset assertion with all channels requesting
        rst_n         = 1'b1;
        bus.in_valid  = 4'hF;
        bus.in_data   = 32'h13121110;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset in_ready",  32'(bus.in_ready),  32'h0);
        check("reset out_sel",   32'(bus.out_sel),   32'h0);
        check("reset out_data",  32'(bus.out_data),  32'h0);
        $display("reset: out_valid=%b in_ready=%b out_sel=%0d", bus.out_valid, bus.in_ready, bus.out_sel);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a cycle drops the held word without waiting for a clock
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 32'h0);
        check("midreset out_data",  32'(bus.out_data),  32'h0);
        check("midreset in_ready",  32'(bus.in_ready),  32'h0);
        $display("midreset: out_valid=%b out_data=%h in_ready=%b", bus.out_valid, bus.out_data, bus.in_ready);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{4'hF, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        step("post-reset ptr0", v);

`ifdef STREAM_MUX_STATS_EN
        do_reset();
        check("stats cleared", 32'(grant_cnt), 32'h0);
        v = '{4'b0010, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        for (int i = 0; i < 20; i++) begin
            step($sformatf("stats%0d", i), v);
            if (i == 13) begin
                check("stats 14 grants", 32'(grant_cnt), 32'h00E0);
            end
        end
        check("stats saturated", 32'(grant_cnt), 32'h00F0);
        $display("stats: grant_cnt=%h", grant_cnt);
`else
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
